// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered RV32I decode stage between fetch and execute.
// Decodes {pc, instr} into a control bundle and queues it in a 1- or 2-entry
// FIFO. A load-use hazard inserts one bubble, flush discards everything queued,
// and stall_cnt saturates at all-ones.
// Optional build macro: RV_DECODE_MULDIV_EN decodes the M extension
// (funct7=0000001). When it is undefined, that funct7 is reported as illegal.
//
// state  | meaning
// -------+----------------------------------------------------------------
// RUN    | normal issue; an incoming reader of a pending load rd is held off
// BUBBLE | one dead cycle after a load-use hold; input is accepted again
module rv_decode_stage #(
  parameter int XLEN      = 32,
  parameter int PC_W      = 32,
  parameter int BUF_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [31:0]      in_instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [3:0]       out_class,
  output logic [3:0]       out_alu_op,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_rf_we,
  output logic             out_mem_rd,
  output logic             out_mem_wr,
  output logic [2:0]       out_mem_type,
  output logic [2:0]       out_br_cond,
  output logic             out_illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [3:0] CLS_ILL = 4'd0, CLS_R = 4'd1, CLS_LOAD = 4'd2, CLS_IMM = 4'd3,
                         CLS_LUI = 4'd4, CLS_AUIPC = 4'd5, CLS_JAL = 4'd6, CLS_JALR = 4'd7,
                         CLS_BR = 4'd8, CLS_STORE = 4'd9;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_SLT = 4'd8, ALU_SLTU = 4'd9;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [3:0]      cls;
    logic [3:0]      alu_op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            rf_we;
    logic            mem_rd;
    logic            mem_wr;
    logic [2:0]      mem_type;
    logic [2:0]      br_cond;
    logic            illegal;
  } bundle_t;

  typedef enum logic {ST_RUN = 1'b0, ST_BUBBLE = 1'b1} state_t;

  state_t     state, state_nxt;
  bundle_t    q [2];
  logic [1:0] count;
  logic [4:0] last_load_rd;
  bundle_t    dec;
  logic       hazard, space, push, pop, full;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  // funct3 -> ALU op shared by R-type and I-type; alt selects SUB/SRA
  function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Pure combinational decode of the presented instruction word
  always_comb begin
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic       use_rs1, use_rs2, wr_rd, bad;
    op      = in_instr[6:0];
    f3      = in_instr[14:12];
    f7      = in_instr[31:25];
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    wr_rd   = 1'b0;
    bad     = 1'b0;
    dec     = '0;
    dec.pc  = in_pc;
    case (op)
      7'b0110011: begin
        dec.cls = CLS_R;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        wr_rd   = 1'b1;
        if (f7 == 7'b0000000) begin
          dec.alu_op = alu_map(f3, 1'b0);
        end else if (f7 == 7'b0100000) begin
          dec.alu_op = alu_map(f3, 1'b1);
          bad        = (f3 != 3'b000) && (f3 != 3'b101);
`ifdef RV_DECODE_MULDIV_EN
        end else if (f7 == 7'b0000001) begin
          // MUL..MULHU map to 10..13, DIV to 14, DIVU/REM/REMU share 15
          if (!f3[2])               dec.alu_op = 4'd10 + {2'b00, f3[1:0]};
          else if (f3 == 3'b100)    dec.alu_op = 4'd14;
          else                      dec.alu_op = 4'd15;
          dec.br_cond = f3;
`endif
        end else begin
          bad = 1'b1;
        end
      end
      7'b0000011: begin
        dec.cls      = CLS_LOAD;
        use_rs1      = 1'b1;
        wr_rd        = 1'b1;
        dec.imm      = sext32({{20{in_instr[31]}}, in_instr[31:20]});
        dec.mem_rd   = 1'b1;
        dec.mem_type = f3;
        bad          = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      7'b0010011: begin
        dec.cls    = CLS_IMM;
        use_rs1    = 1'b1;
        wr_rd      = 1'b1;
        dec.imm    = sext32({{20{in_instr[31]}}, in_instr[31:20]});
        dec.alu_op = alu_map(f3, (f3 == 3'b101) && f7[5]);
        if (f3 == 3'b001)      bad = (f7 != 7'b0000000);
        else if (f3 == 3'b101) bad = (f7 != 7'b0000000) && (f7 != 7'b0100000);
      end
      7'b0110111: begin
        dec.cls = CLS_LUI;
        wr_rd   = 1'b1;
        dec.imm = sext32({in_instr[31:12], 12'b0});
      end
      7'b0010111: begin
        dec.cls = CLS_AUIPC;
        wr_rd   = 1'b1;
        dec.imm = sext32({in_instr[31:12], 12'b0});
      end
      7'b1101111: begin
        dec.cls = CLS_JAL;
        wr_rd   = 1'b1;
        dec.imm = sext32({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0});
      end
      7'b1100111: begin
        dec.cls = CLS_JALR;
        use_rs1 = 1'b1;
        wr_rd   = 1'b1;
        dec.imm = sext32({{20{in_instr[31]}}, in_instr[31:20]});
        bad     = (f3 != 3'b000);
      end
      7'b1100011: begin
        dec.cls     = CLS_BR;
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        dec.alu_op  = ALU_SUB;
        dec.imm     = sext32({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0});
        dec.br_cond = f3;
        bad         = (f3 == 3'b010) || (f3 == 3'b011);
      end
      7'b0100011: begin
        dec.cls      = CLS_STORE;
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
        dec.imm      = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
        dec.mem_wr   = 1'b1;
        dec.mem_type = f3;
        bad          = (f3[2] == 1'b1) || (f3 == 3'b011);
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec         = '0;
      dec.pc      = in_pc;
      dec.illegal = 1'b1;
    end else begin
      dec.rs1   = use_rs1 ? in_instr[19:15] : 5'd0;
      dec.rs2   = use_rs2 ? in_instr[24:20] : 5'd0;
      dec.rf_we = wr_rd && (in_instr[11:7] != 5'd0);
      dec.rd    = dec.rf_we ? in_instr[11:7] : 5'd0;
    end
  end

  // Handshake, hazard detection and next-state selection
  always_comb begin
    full      = (count == 2'(BUF_DEPTH));
    space     = (BUF_DEPTH == 1) ? (!full || out_ready) : !full;
    hazard    = (state == ST_RUN) && in_valid && (last_load_rd != 5'd0) &&
                ((dec.rs1 == last_load_rd) || (dec.rs2 == last_load_rd));
    in_ready  = !rst && !flush && space && !hazard;
    out_valid = (count != 2'd0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    state_nxt = state;
    case (state)
      ST_RUN:    if (hazard) state_nxt = ST_BUBBLE;
      ST_BUBBLE: state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
    if (flush) state_nxt = ST_RUN;
  end

  // Queue, FSM state, load tracking and stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RUN;
      count        <= 2'd0;
      q[0]         <= '0;
      q[1]         <= '0;
      last_load_rd <= 5'd0;
      stall_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_BUBBLE && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush) begin
        count        <= 2'd0;
        last_load_rd <= 5'd0;
      end else begin
        if (push)
          last_load_rd <= (dec.cls == CLS_LOAD) ? dec.rd : 5'd0;
        case ({push, pop})
          2'b11: begin
            if (count == 2'd1) begin
              q[0] <= dec;
            end else begin
              q[0] <= q[1];
              q[1] <= dec;
            end
          end
          2'b10: begin
            if (count == 2'd0) q[0] <= dec;
            else               q[1] <= dec;
            count <= count + 2'd1;
          end
          2'b01: begin
            q[0]  <= q[1];
            count <= count - 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign out_pc       = q[0].pc;
  assign out_class    = q[0].cls;
  assign out_alu_op   = q[0].alu_op;
  assign out_rs1      = q[0].rs1;
  assign out_rs2      = q[0].rs2;
  assign out_rd       = q[0].rd;
  assign out_imm      = q[0].imm;
  assign out_rf_we    = q[0].rf_we;
  assign out_mem_rd   = q[0].mem_rd;
  assign out_mem_wr   = q[0].mem_wr;
  assign out_mem_type = q[0].mem_type;
  assign out_br_cond  = q[0].br_cond;
  assign out_illegal  = q[0].illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage (default build, 2-entry queue, 2-bit stall counter).
module tb_rv_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_pc, in_instr, out_pc, out_imm;
  logic [3:0]  out_class, out_alu_op;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_rf_we, out_mem_rd, out_mem_wr, out_illegal;
  logic [2:0]  out_mem_type, out_br_cond;
  logic [1:0]  stall_cnt;

  int n_checks = 0;
  int n_err    = 0;

  rv_decode_stage #(.XLEN(32), .PC_W(32), .BUF_DEPTH(2), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_class(out_class), .out_alu_op(out_alu_op), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm), .out_rf_we(out_rf_we),
    .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_mem_type(out_mem_type),
    .out_br_cond(out_br_cond), .out_illegal(out_illegal), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic feed(input logic [31:0] pc, input logic [31:0] instr);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr;
    tick();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_pc = 32'h0; in_instr = 32'h00500093;

    // T1 reset with in_valid high
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    tick();
    chk("rst_in_ready2", 64'(in_ready), 64'h0);
    chk("rst_out_valid2", 64'(out_valid), 64'h0);
    chk("rst_stall", 64'(stall_cnt), 64'h0);
    chk("rst_class", 64'(out_class), 64'h0);
    chk("rst_imm", 64'(out_imm), 64'h0);
    rst = 1'b0; in_valid = 1'b0;
    #1 chk("post_rst_in_ready", 64'(in_ready), 64'h1);

    // T2 addi x1,x0,5 then add x3,x1,x2
    feed(32'h100, 32'h00500093);
    chk("t2_addi_valid", 64'(out_valid), 64'h1);
    chk("t2_addi_pc", 64'(out_pc), 64'h100);
    chk("t2_addi_class", 64'(out_class), 64'h3);
    chk("t2_addi_imm", 64'(out_imm), 64'h5);
    chk("t2_addi_rd", 64'(out_rd), 64'h1);
    chk("t2_addi_we", 64'(out_rf_we), 64'h1);
    in_pc = 32'h104; in_instr = 32'h002081B3;
    #1 chk("t2_add_in_ready", 64'(in_ready), 64'h1);
    tick();
    chk("t2_add_pc", 64'(out_pc), 64'h104);
    chk("t2_add_class", 64'(out_class), 64'h1);
    chk("t2_add_alu", 64'(out_alu_op), 64'h0);
    chk("t2_add_rs1", 64'(out_rs1), 64'h1);
    chk("t2_add_rs2", 64'(out_rs2), 64'h2);
    chk("t2_add_rd", 64'(out_rd), 64'h3);
    chk("t2_add_imm", 64'(out_imm), 64'h0);
    chk("t2_stall", 64'(stall_cnt), 64'h0);
    in_valid = 1'b0;
    tick();
    chk("t2_drained", 64'(out_valid), 64'h0);

    // T3 lw x5,0(x2) then add x6,x5,x7: one bubble
    feed(32'h200, 32'h00012283);
    chk("t3_lw_class", 64'(out_class), 64'h2);
    chk("t3_lw_memrd", 64'(out_mem_rd), 64'h1);
    chk("t3_lw_memtype", 64'(out_mem_type), 64'h2);
    chk("t3_lw_rd", 64'(out_rd), 64'h5);
    chk("t3_lw_rs1", 64'(out_rs1), 64'h2);
    chk("t3_lw_rs2", 64'(out_rs2), 64'h0);
    in_pc = 32'h204; in_instr = 32'h00728333;
    #1 chk("t3_hazard_in_ready", 64'(in_ready), 64'h0);
    tick();
    chk("t3_bubble_out_valid", 64'(out_valid), 64'h0);
    chk("t3_bubble_in_ready", 64'(in_ready), 64'h1);
    tick();
    chk("t3_add_valid", 64'(out_valid), 64'h1);
    chk("t3_add_pc", 64'(out_pc), 64'h204);
    chk("t3_add_rs1", 64'(out_rs1), 64'h5);
    chk("t3_add_rs2", 64'(out_rs2), 64'h7);
    chk("t3_add_rd", 64'(out_rd), 64'h6);
    chk("t3_stall", 64'(stall_cnt), 64'h1);
    in_valid = 1'b0;
    tick();

    // T4 backpressure: out_ready low for 4 cycles, 3 instrs offered
    out_ready = 1'b0;
    feed(32'h300, 32'h00100093);
    in_pc = 32'h304; in_instr = 32'h00200113;
    #1 chk("t4_in_ready_1", 64'(in_ready), 64'h1);
    tick();
    in_pc = 32'h308; in_instr = 32'h00300193;
    #1 chk("t4_full_in_ready", 64'(in_ready), 64'h0);
    chk("t4_hold_pc_a", 64'(out_pc), 64'h300);
    tick();
    chk("t4_hold_pc_b", 64'(out_pc), 64'h300);
    chk("t4_hold_imm", 64'(out_imm), 64'h1);
    chk("t4_hold_in_ready", 64'(in_ready), 64'h0);
    tick();
    chk("t4_hold_pc_c", 64'(out_pc), 64'h300);
    out_ready = 1'b1;
    #1 chk("t4_in_ready_registered", 64'(in_ready), 64'h0);
    tick();
    chk("t4_drain_pc1", 64'(out_pc), 64'h304);
    chk("t4_drain_rd1", 64'(out_rd), 64'h2);
    chk("t4_in_ready_back", 64'(in_ready), 64'h1);
    tick();
    chk("t4_drain_pc2", 64'(out_pc), 64'h308);
    chk("t4_drain_imm2", 64'(out_imm), 64'h3);
    in_valid = 1'b0;
    tick();
    chk("t4_empty", 64'(out_valid), 64'h0);

    // T5 flush with full queue and a pending load-use hold
    out_ready = 1'b0;
    feed(32'h400, 32'h00100093);
    feed(32'h404, 32'h00012283);
    in_pc = 32'h408; in_instr = 32'h00728333; flush = 1'b1;
    #1 chk("t5_flush_in_ready", 64'(in_ready), 64'h0);
    tick();
    flush = 1'b0;
    #1 chk("t5_out_valid", 64'(out_valid), 64'h0);
    chk("t5_in_ready", 64'(in_ready), 64'h1);
    out_ready = 1'b1;
    tick();
    chk("t5_next_pc", 64'(out_pc), 64'h408);
    chk("t5_next_valid", 64'(out_valid), 64'h1);
    chk("t5_stall", 64'(stall_cnt), 64'h1);

    // T6 and decode vectors, streamed one per cycle
    feed(32'h500, 32'h02208033);
`ifdef RV_DECODE_MULDIV_EN
    chk("t6_mul_class", 64'(out_class), 64'h1);
    chk("t6_mul_alu", 64'(out_alu_op), 64'hA);
    chk("t6_mul_illegal", 64'(out_illegal), 64'h0);
`else
    chk("t6_mul_class", 64'(out_class), 64'h0);
    chk("t6_mul_illegal", 64'(out_illegal), 64'h1);
`endif
    chk("t6_mul_we", 64'(out_rf_we), 64'h0);
    chk("t6_mul_pc", 64'(out_pc), 64'h500);
    feed(32'h504, 32'h00512423);
    chk("sw_class", 64'(out_class), 64'h9);
    chk("sw_memwr", 64'(out_mem_wr), 64'h1);
    chk("sw_imm", 64'(out_imm), 64'h8);
    chk("sw_rs2", 64'(out_rs2), 64'h5);
    chk("sw_we", 64'(out_rf_we), 64'h0);
    feed(32'h508, 32'hFE208EE3);
    chk("beq_class", 64'(out_class), 64'h8);
    chk("beq_imm", 64'(out_imm), 64'hFFFFFFFC);
    chk("beq_rd", 64'(out_rd), 64'h0);
    feed(32'h50C, 32'h12345237);
    chk("lui_class", 64'(out_class), 64'h4);
    chk("lui_imm", 64'(out_imm), 64'h12345000);
    chk("lui_rd", 64'(out_rd), 64'h4);
    feed(32'h510, 32'h010000EF);
    chk("jal_class", 64'(out_class), 64'h6);
    chk("jal_imm", 64'(out_imm), 64'h10);
    chk("jal_rd", 64'(out_rd), 64'h1);
    feed(32'h514, 32'h402081B3);
    chk("sub_alu", 64'(out_alu_op), 64'h1);
    feed(32'h518, 32'h40315093);
    chk("srai_alu", 64'(out_alu_op), 64'h7);
    chk("srai_imm", 64'(out_imm), 64'h403);
    feed(32'h51C, 32'h042081B3);
    chk("badf7_illegal", 64'(out_illegal), 64'h1);
    chk("badf7_we", 64'(out_rf_we), 64'h0);
    feed(32'h520, 32'hFFFFFFFF);
    chk("badop_illegal", 64'(out_illegal), 64'h1);
    chk("badop_class", 64'(out_class), 64'h0);
    chk("badop_pc", 64'(out_pc), 64'h520);
    in_valid = 1'b0;
    tick();
    chk("vec_drained", 64'(out_valid), 64'h0);

    // stall counter saturation (2-bit counter)
    for (int i = 0; i < 3; i++) begin
      feed(32'h600, 32'h00012283);
      in_instr = 32'h00728333;
      #1 chk("sat_hazard_in_ready", 64'(in_ready), 64'h0);
      tick();
      tick();
      chk("sat_stall", 64'(stall_cnt), (i == 0) ? 64'h2 : 64'h3);
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("sat_final", 64'(stall_cnt), 64'h3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
